// File: rtl/uart_pkg.sv
// Shared types and constants for the UART rx->tx elastic buffer.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_TIMEOUT    = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } drain_state_t;

endpackage

// File: rtl/uart_rx_tx_fifo_if.sv
// Receiver/transmitter-side signal bundle of the elastic buffer.
// fifo_level exists only when UART_FIFO_LEVEL_EN is defined.
interface uart_rx_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_FIFO_DEPTH
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              drain_en;
  logic              tx_ready;
  logic              ovf_clr;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              fifo_empty;
  logic              fifo_full;
  logic              overflow;
`ifdef UART_FIFO_LEVEL_EN
  logic [CNT_W-1:0]  fifo_level;

  modport master (
    output rx_data, rx_valid, drain_en, tx_ready, ovf_clr,
    input  tx_data, tx_start, fifo_empty, fifo_full, overflow, fifo_level
  );
  modport slave (
    input  rx_data, rx_valid, drain_en, tx_ready, ovf_clr,
    output tx_data, tx_start, fifo_empty, fifo_full, overflow, fifo_level
  );
`else
  modport master (
    output rx_data, rx_valid, drain_en, tx_ready, ovf_clr,
    input  tx_data, tx_start, fifo_empty, fifo_full, overflow
  );
  modport slave (
    input  rx_data, rx_valid, drain_en, tx_ready, ovf_clr,
    output tx_data, tx_start, fifo_empty, fifo_full, overflow
  );
`endif

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO storage with wrap-bit pointers; head is read combinationally.
// level_o exists only when UART_FIFO_LEVEL_EN is defined.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_dat_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_dat_o,
  output logic                     empty_o,
  output logic                     full_o
`ifdef UART_FIFO_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]   level_o
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;

  assign wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

`ifdef UART_FIFO_LEVEL_EN
  assign level_o = wr_ptr_q - rd_ptr_q;
`endif

endmodule

// File: rtl/uart_rx_tx_fifo.sv
// Elastic byte buffer from UART receiver to transmitter; paces tx_start against tx_ready.
// Push-to-start latency 2 cycles; drops pushes only when full (sticky overflow). Optional UART_FIFO_LEVEL_EN.
module uart_rx_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic             clk_int,
  input  logic             uart_reset,
  uart_rx_tx_fifo_if.slave bus
);

  localparam int TMO_W = $clog2(UART_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(UART_TIMEOUT - 1);

  drain_state_t      state_q, state_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              ovf_q, ovf_d;

  logic              push, pop, drop;
  logic              empty, full;
  logic [DATA_W-1:0] head;

  // A full buffer still accepts a byte when the head leaves in the same cycle.
  assign push = bus.rx_valid && (!full || pop);
  assign drop = bus.rx_valid && full && !pop;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_i      (clk_int),
    .rst_ni     (uart_reset),
    .push_i     (push),
    .push_dat_i (bus.rx_data),
    .pop_i      (pop),
    .head_dat_o (head),
    .empty_o    (empty),
    .full_o     (full)
`ifdef UART_FIFO_LEVEL_EN
    ,
    .level_o    (bus.fifo_level)
`endif
  );

  always_comb begin
    state_d    = state_q;
    tmo_d      = '0;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    case (state_q)
      IDLE: begin
        if (bus.drain_en && !empty && bus.tx_ready) begin
          pop        = 1'b1;
          tx_data_d  = head;
          tx_start_d = 1'b1;
          state_d    = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // Timeout covers a transmitter that never visibly drops ready.
        if (!bus.tx_ready || tmo_q == TMO_LAST) begin
          state_d = WAIT_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (bus.tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ovf_d = drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : ovf_q);

  always_ff @(posedge clk_int or negedge uart_reset) begin
    if (!uart_reset) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_start   = tx_start_q;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.overflow   = ovf_q;

endmodule
